// File: rtl/fft_pkg.sv
// Shared types and default sizing for the radix-2 DIT FFT sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int N_LOG2_DEF = 10;
  localparam int RD_LAT_DEF = 1;

  localparam int N      = 1 << N_LOG2_DEF;
  localparam int HALF   = N / 2;
  localparam int D      = RD_LAT_DEF + 1;
  localparam int ADDR_W = N_LOG2_DEF;
  localparam int TW_W   = N_LOG2_DEF - 1;

  // Bits needed to hold a stage index 0..n_log2-1.
  function automatic int stage_w(input int n_log2);
    return (n_log2 > 1) ? $clog2(n_log2) : 1;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// Butterfly address generator: (stage, butterfly index) -> operand pair and twiddle index.
module fft_agu
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  localparam int SW = stage_w(N_LOG2),
  localparam int AW = N_LOG2,
  localparam int KW = N_LOG2 - 1
) (
  input  logic [SW-1:0] s,
  input  logic [KW-1:0] k,
  output logic [AW-1:0] a0,
  output logic [AW-1:0] a1,
  output logic [KW-1:0] tw
);

  logic [KW-1:0] mask;
  logic [KW-1:0] pos;
  logic [KW-1:0] grp;

  // Split k into position-in-group and group number; at the last stage the
  // mask wraps to all ones, which is exactly the full-width position.
  always_comb begin
    mask = (KW'(1) << s) - KW'(1);
    pos  = k & mask;
    grp  = k >> s;
    a0   = ({1'b0, grp} << s << 1) + {1'b0, pos};
    a1   = a0 + (AW'(1) << s);
    tw   = pos << (SW'(N_LOG2 - 1) - s);
  end

endmodule

// File: rtl/fft_ctrl.sv
// Sequencer for the ping-pong radix-2 butterfly datapath.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one butterfly read per cycle, k = 0..N/2-1 of stage s
// DRAIN | D cycles letting the last reads of the stage reach their writes
// FIN   | one-cycle done pulse; a start seen here launches the next run
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              result_in_B,
  output logic [N_LOG2-1:0] addr0_AMEM,
  output logic [N_LOG2-1:0] addr1_AMEM,
  output logic [N_LOG2-1:0] addr0_BMEM,
  output logic [N_LOG2-1:0] addr1_BMEM,
  output logic              we_AMEM,
  output logic              we_BMEM,
  output logic [N_LOG2-2:0] addr_CROM,
  output logic              sel_mux,
  output logic              en_REG
);

  localparam int AW = N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int SW = stage_w(N_LOG2);
  localparam int PD = RD_LAT + 1;
  localparam int CW = $clog2(PD);

  localparam logic [SW-1:0] S_LAST    = SW'(N_LOG2 - 1);
  localparam logic [KW-1:0] K_LAST    = '1;
  localparam logic [CW-1:0] C_LOAD    = CW'(PD - 1);
  localparam logic          RES_FINAL = 1'(N_LOG2 % 2);

  state_t        state, state_nxt;
  logic [SW-1:0] s_q, s_nxt;
  logic [KW-1:0] k_q, k_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          res_q, res_nxt;

  logic [AW-1:0] a0, a1;
  logic [KW-1:0] tw;
  logic          rd_vld;

  logic [PD-1:0] vld_pipe, par_pipe;
  logic [AW-1:0] a0_pipe [PD];
  logic [AW-1:0] a1_pipe [PD];
  logic          cap_vld, cap_par, wr_vld, wr_par;

  logic [AW-1:0] hold_a0_amem, hold_a1_amem, hold_a0_bmem, hold_a1_bmem;
  logic [KW-1:0] hold_tw;

  fft_agu #(.N_LOG2(N_LOG2)) u_agu (
    .s  (s_q),
    .k  (k_q),
    .a0 (a0),
    .a1 (a1),
    .tw (tw)
  );

  // State, stage/butterfly counters, drain timer and result flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      s_q   <= '0;
      k_q   <= '0;
      cnt_q <= '0;
      res_q <= 1'b0;
    end else begin
      state <= state_nxt;
      s_q   <= s_nxt;
      k_q   <= k_nxt;
      cnt_q <= cnt_nxt;
      res_q <= res_nxt;
    end
  end

  // Next-state logic; FIN may accept a held start so back-to-back runs have no gap cycle.
  always_comb begin
    state_nxt = state;
    s_nxt     = s_q;
    k_nxt     = k_q;
    cnt_nxt   = cnt_q;
    res_nxt   = res_q;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          k_nxt     = '0;
          res_nxt   = 1'b0;
        end
      end
      RUN: begin
        busy  = 1'b1;
        k_nxt = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = C_LOAD;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        cnt_nxt = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (s_q == S_LAST) begin
            state_nxt = FIN;
            res_nxt   = RES_FINAL;
          end else begin
            state_nxt = RUN;
            s_nxt     = s_q + 1'b1;
            k_nxt     = '0;
          end
        end
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          k_nxt     = '0;
          res_nxt   = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_vld      = (state == RUN);
  assign result_in_B = res_q;

  // Delay lines carrying each read's validity, source parity and operand pair to its capture/write slots.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      par_pipe <= '0;
      for (int j = 0; j < PD; j++) begin
        a0_pipe[j] <= '0;
        a1_pipe[j] <= '0;
      end
    end else begin
      vld_pipe   <= {vld_pipe[PD-2:0], rd_vld};
      par_pipe   <= {par_pipe[PD-2:0], s_q[0]};
      a0_pipe[0] <= a0;
      a1_pipe[0] <= a1;
      for (int j = 1; j < PD; j++) begin
        a0_pipe[j] <= a0_pipe[j-1];
        a1_pipe[j] <= a1_pipe[j-1];
      end
    end
  end

  assign cap_vld = vld_pipe[RD_LAT-1];
  assign cap_par = par_pipe[RD_LAT-1];
  assign wr_vld  = vld_pipe[PD-1];
  assign wr_par  = par_pipe[PD-1];

  // Memory-side muxing: source gets live addresses, destination gets delayed ones, idle ports hold.
  always_comb begin
    addr0_AMEM = hold_a0_amem;
    addr1_AMEM = hold_a1_amem;
    addr0_BMEM = hold_a0_bmem;
    addr1_BMEM = hold_a1_bmem;
    addr_CROM  = hold_tw;
    we_AMEM    = 1'b0;
    we_BMEM    = 1'b0;
    if (rd_vld) begin
      if (s_q[0]) begin
        addr0_BMEM = a0;
        addr1_BMEM = a1;
      end else begin
        addr0_AMEM = a0;
        addr1_AMEM = a1;
      end
      addr_CROM = tw;
    end
    if (wr_vld) begin
      if (wr_par) begin
        addr0_AMEM = a0_pipe[PD-1];
        addr1_AMEM = a1_pipe[PD-1];
        we_AMEM    = 1'b1;
      end else begin
        addr0_BMEM = a0_pipe[PD-1];
        addr1_BMEM = a1_pipe[PD-1];
        we_BMEM    = 1'b1;
      end
    end
    en_REG  = ~cap_vld;
    sel_mux = cap_vld & cap_par;
  end

  // Remember the last driven addresses so idle ports do not toggle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_a0_amem <= '0;
      hold_a1_amem <= '0;
      hold_a0_bmem <= '0;
      hold_a1_bmem <= '0;
      hold_tw      <= '0;
    end else begin
      hold_a0_amem <= addr0_AMEM;
      hold_a1_amem <= addr1_AMEM;
      hold_a0_bmem <= addr0_BMEM;
      hold_a1_bmem <= addr1_BMEM;
      hold_tw      <= addr_CROM;
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl with N = 8, RD_LAT = 1.
module tb_fft_ctrl;

  localparam int NL      = 3;
  localparam int RL      = 1;
  localparam int H       = (1 << NL) / 2;
  localparam int DD      = RL + 1;
  localparam int RUN_LEN = NL * (H + DD) + 1;
  localparam int MAXC    = 160;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, result_in_B;
  logic [NL-1:0] addr0_AMEM, addr1_AMEM, addr0_BMEM, addr1_BMEM;
  logic          we_AMEM, we_BMEM;
  logic [NL-2:0] addr_CROM;
  logic          sel_mux, en_REG;

  fft_ctrl #(.N_LOG2(NL), .RD_LAT(RL)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .result_in_B (result_in_B),
    .addr0_AMEM  (addr0_AMEM),
    .addr1_AMEM  (addr1_AMEM),
    .addr0_BMEM  (addr0_BMEM),
    .addr1_BMEM  (addr1_BMEM),
    .we_AMEM     (we_AMEM),
    .we_BMEM     (we_BMEM),
    .addr_CROM   (addr_CROM),
    .sel_mux     (sel_mux),
    .en_REG      (en_REG)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int en_a_cnt = 0;
  int free_from = 0;

  // Expected per-cycle events, indexed by cycle number.
  bit e_rd[MAXC], e_rd_b[MAXC], e_cap[MAXC], e_cap_b[MAXC];
  bit e_wr[MAXC], e_wr_b[MAXC], e_busy[MAXC], e_done[MAXC];
  int e_a0[MAXC], e_a1[MAXC], e_tw[MAXC], e_w0[MAXC], e_w1[MAXC];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_rd[i] = 0; e_rd_b[i] = 0; e_cap[i] = 0; e_cap_b[i] = 0;
      e_wr[i] = 0; e_wr_b[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_a0[i] = 0; e_a1[i] = 0; e_tw[i] = 0; e_w0[i] = 0; e_w1[i] = 0;
    end
  endtask

  // Plan a whole run accepted in cycle c0, straight from the stage/butterfly arithmetic.
  task automatic schedule_run(input int c0);
    for (int s = 0; s < NL; s++) begin
      for (int k = 0; k < H; k++) begin
        int span, pos, grp, a0, a1, tw, t;
        span = 1 << s;
        pos  = k % span;
        grp  = k / span;
        a0   = grp * 2 * span + pos;
        a1   = a0 + span;
        tw   = pos * (1 << (NL - 1 - s));
        t    = c0 + s * (H + DD) + 1 + k;
        e_rd[t] = 1; e_rd_b[t] = (s % 2 == 1);
        e_a0[t] = a0; e_a1[t] = a1; e_tw[t] = tw;
        e_cap[t + RL] = 1; e_cap_b[t + RL] = (s % 2 == 1);
        e_wr[t + DD] = 1; e_wr_b[t + DD] = (s % 2 == 0);
        e_w0[t + DD] = a0; e_w1[t + DD] = a1;
      end
    end
    for (int c = c0 + 1; c < c0 + RUN_LEN; c++) e_busy[c] = 1;
    e_done[c0 + RUN_LEN] = 1;
    free_from = c0 + RUN_LEN;
  endtask

  // Model update and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    int c;
    c = cyc;
    if (!rstn) begin
      clear_from(c);
      free_from = c;
      chk("rst_addr0_AMEM", int'(addr0_AMEM), 0);
      chk("rst_addr1_BMEM", int'(addr1_BMEM), 0);
      chk("rst_addr_CROM", int'(addr_CROM), 0);
      chk("rst_sel_mux", int'(sel_mux), 0);
      chk("rst_result_in_B", int'(result_in_B), 0);
    end else if (start && c >= free_from) begin
      schedule_run(c);
    end
    if (c < MAXC) begin
      chk("we_AMEM", int'(we_AMEM), int'(e_wr[c] && !e_wr_b[c]));
      chk("we_BMEM", int'(we_BMEM), int'(e_wr[c] && e_wr_b[c]));
      chk("en_REG", int'(en_REG), int'(!e_cap[c]));
      chk("busy", int'(busy), int'(e_busy[c]));
      chk("done", int'(done), int'(e_done[c]));
      chk("we_both", int'(we_AMEM & we_BMEM), 0);
      if (e_cap[c]) chk("sel_mux", int'(sel_mux), int'(e_cap_b[c]));
      if (e_done[c]) chk("result_in_B", int'(result_in_B), NL % 2);
      if (e_rd[c]) begin
        if (e_rd_b[c]) begin
          chk("rd_addr0_BMEM", int'(addr0_BMEM), e_a0[c]);
          chk("rd_addr1_BMEM", int'(addr1_BMEM), e_a1[c]);
          chk("rd_wr_clash_B", int'(we_BMEM), 0);
        end else begin
          chk("rd_addr0_AMEM", int'(addr0_AMEM), e_a0[c]);
          chk("rd_addr1_AMEM", int'(addr1_AMEM), e_a1[c]);
          chk("rd_wr_clash_A", int'(we_AMEM), 0);
        end
        chk("addr_CROM", int'(addr_CROM), e_tw[c]);
      end
      if (e_wr[c]) begin
        if (e_wr_b[c]) begin
          chk("wr_addr0_BMEM", int'(addr0_BMEM), e_w0[c]);
          chk("wr_addr1_BMEM", int'(addr1_BMEM), e_w1[c]);
        end else begin
          chk("wr_addr0_AMEM", int'(addr0_AMEM), e_w0[c]);
          chk("wr_addr1_AMEM", int'(addr1_AMEM), e_w1[c]);
        end
      end
    end
    if (done) done_cnt++;
    if (c >= 5 && c <= 24 && !en_REG) en_a_cnt++;
  end

  // Advance to just after the rising edge that begins cycle n.
  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance to the falling edge inside cycle n.
  task automatic at_neg(input int n);
    at_cyc(n);
    @(negedge clk);
  endtask

  initial begin
    #1 rstn = 1'b0;
    at_cyc(3);
    rstn = 1'b1;

    // Run A accepted in cycle 5, done expected in cycle 24.
    at_cyc(5);  start = 1'b1;
    at_cyc(6);  start = 1'b0;
    at_neg(8);
    chk("lit_s0_we_BMEM", int'(we_BMEM), 1);
    chk("lit_s0_w0_BMEM", int'(addr0_BMEM), 0);
    chk("lit_s0_w1_BMEM", int'(addr1_BMEM), 1);
    at_cyc(10); start = 1'b1;
    at_cyc(11); start = 1'b0;
    at_neg(13);
    chk("lit_s1_r0_BMEM", int'(addr0_BMEM), 1);
    chk("lit_s1_r1_BMEM", int'(addr1_BMEM), 3);
    chk("lit_s1_tw", int'(addr_CROM), 2);
    chk("lit_s1_sel", int'(sel_mux), 1);
    chk("lit_s1_en", int'(en_REG), 0);
    at_neg(15);
    chk("lit_s1_we_AMEM", int'(we_AMEM), 1);
    chk("lit_s1_w0_AMEM", int'(addr0_AMEM), 1);
    chk("lit_s1_w1_AMEM", int'(addr1_AMEM), 3);
    at_neg(21);
    chk("lit_s2_r0_AMEM", int'(addr0_AMEM), 3);
    chk("lit_s2_r1_AMEM", int'(addr1_AMEM), 7);
    chk("lit_s2_tw", int'(addr_CROM), 3);
    at_neg(24);
    chk("lit_a_done", int'(done), 1);
    chk("lit_a_result", int'(result_in_B), 1);
    chk("lit_a_busy", int'(busy), 0);

    // Run B with start held through its FIN: run C follows without a gap.
    at_cyc(30); start = 1'b1;
    at_neg(49);
    chk("lit_b_done", int'(done), 1);
    at_cyc(50); start = 1'b0;
    at_neg(67);
    chk("lit_c_not_done", int'(done), 0);
    at_neg(68);
    chk("lit_c_done", int'(done), 1);

    // Run D aborted by reset during stage 1, k=2.
    at_cyc(75); start = 1'b1;
    at_cyc(76); start = 1'b0;
    at_cyc(84);
    rstn = 1'b0;
    #1;
    chk("lit_abort_we_AMEM", int'(we_AMEM), 0);
    chk("lit_abort_en_REG", int'(en_REG), 1);
    chk("lit_abort_busy", int'(busy), 0);
    at_cyc(86); rstn = 1'b1;
    at_neg(94);
    chk("lit_d_no_done", int'(done), 0);

    // Run E after the abort completes normally.
    at_cyc(100); start = 1'b1;
    at_cyc(101); start = 1'b0;
    at_neg(118);
    chk("lit_e_busy", int'(busy), 1);
    at_neg(119);
    chk("lit_e_done", int'(done), 1);
    chk("lit_e_busy_low", int'(busy), 0);
    at_neg(125);

    chk("done_count", done_cnt, 4);
    chk("en_low_run_a", en_a_cnt, 12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
